hex_display_mux: RTL and testbench

//  Parametrised, time-multiplexed driver for N common-anode 7-segment digits; successor of the fixed 4-digit driver.

---
 rtl/hex_display_mux.sv | 134 +++++++++++++
 tb/tb_hex_display_mux.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/hex_display_mux.sv
// Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits with
// blanking dead time, PWM brightness, leading-zero suppression and frame-synchronous loading.
module hex_display_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 4096,
    parameter int BLANK_CYCLES = 64,
    parameter int BRIGHT_W     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] i_data,
    input  logic [NUM_DIGITS-1:0]   i_dot_mask,
    input  logic [NUM_DIGITS-1:0]   i_digit_en,
    input  logic                    i_load,
    input  logic                    i_lz_blank,
    input  logic [BRIGHT_W-1:0]     i_brightness,
    output logic [NUM_DIGITS-1:0]   o_anodes,
    output logic [7:0]              o_segments,
    output logic                    o_frame_done
);

    localparam int CNT_W = $clog2(DIGIT_CYCLES);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'h0: seg_decode = 7'b1111110;
            4'h1: seg_decode = 7'b0110000;
            4'h2: seg_decode = 7'b1101101;
            4'h3: seg_decode = 7'b1111001;
            4'h4: seg_decode = 7'b0110011;
            4'h5: seg_decode = 7'b1011011;
            4'h6: seg_decode = 7'b1011111;
            4'h7: seg_decode = 7'b1110000;
            4'h8: seg_decode = 7'b1111111;
            4'h9: seg_decode = 7'b1111011;
            4'hA: seg_decode = 7'b1110111;
            4'hB: seg_decode = 7'b0011111;
            4'hC: seg_decode = 7'b1001110;
            4'hD: seg_decode = 7'b0111101;
            4'hE: seg_decode = 7'b1001111;
            default: seg_decode = 7'b1000111;
        endcase
    endfunction

    logic [CNT_W-1:0]        cnt_p0;
    logic [IDX_W-1:0]        idx_p0;
    logic                    boundary_p0;
    logic [4*NUM_DIGITS-1:0] pend_data, act_data;
    logic [NUM_DIGITS-1:0]   pend_dots, pend_en, act_dots, act_en;
    logic                    pend_flag;
    logic [3:0]              nib_p0;
    logic                    en_p0, dot_p0, tail_zero_p0, blanked_p0, lit_p0;

    assign boundary_p0 = (cnt_p0 == CNT_W'(DIGIT_CYCLES - 1)) &&
                         (idx_p0 == IDX_W'(NUM_DIGITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p0 <= '0;
            idx_p0 <= '0;
        end else if (cnt_p0 == CNT_W'(DIGIT_CYCLES - 1)) begin
            cnt_p0 <= '0;
            idx_p0 <= (idx_p0 == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_p0 + 1'b1;
        end else begin
            cnt_p0 <= cnt_p0 + 1'b1;
        end
    end

    // A load landing on the boundary cycle must survive as pending, so it is assigned last.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_flag <= 1'b0;
            act_data  <= '0;
            act_dots  <= '0;
            act_en    <= '1;
        end else begin
            if (boundary_p0 && pend_flag) begin
                act_data  <= pend_data;
                act_dots  <= pend_dots;
                act_en    <= pend_en;
                pend_flag <= 1'b0;
            end
            if (i_load) pend_flag <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_load) begin
            pend_data <= i_data;
            pend_dots <= i_dot_mask;
            pend_en   <= i_digit_en;
        end
    end

    always_comb begin
        nib_p0       = 4'h0;
        en_p0        = 1'b0;
        dot_p0       = 1'b0;
        tail_zero_p0 = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_p0 == IDX_W'(k)) begin
                nib_p0 = act_data[4*k +: 4];
                en_p0  = act_en[k];
                dot_p0 = act_dots[k];
            end
            if ((IDX_W'(k) >= idx_p0) && (act_data[4*k +: 4] != 4'h0))
                tail_zero_p0 = 1'b0;
        end
        blanked_p0 = i_lz_blank && (idx_p0 != '0) && tail_zero_p0;
        lit_p0     = (cnt_p0 >= CNT_W'(BLANK_CYCLES)) &&
                     (cnt_p0[BRIGHT_W-1:0] <= i_brightness) &&
                     en_p0 && !(blanked_p0 && !dot_p0);
    end

    // Stage p0 -> pins: every output registered together
    always_ff @(posedge clk) begin
        if (rst) begin
            o_anodes     <= '1;
            o_segments   <= '0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= boundary_p0;
            if (lit_p0) begin
                o_anodes   <= ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_p0);
                o_segments <= {(blanked_p0 ? 7'b0 : seg_decode(nib_p0)), dot_p0};
            end else begin
                o_anodes   <= '1;
                o_segments <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hex_display_mux.sv
// Bench for hex_display_mux: directed scenarios plus randomized traffic compared
// cycle by cycle against an arithmetic model of the scan timeline.
module tb_hex_display_mux;

    localparam int ND = 4, DC = 16, BC = 4, BW = 2;
    localparam int FRAME = ND * DC;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   i_data = '0;
    logic [3:0]    i_dot_mask = '0, i_digit_en = '1;
    logic          i_load = 1'b0, i_lz_blank = 1'b0;
    logic [BW-1:0] i_brightness = '1;
    logic [3:0]    o_anodes;
    logic [7:0]    o_segments;
    logic          o_frame_done;

    hex_display_mux #(.NUM_DIGITS(ND), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC), .BRIGHT_W(BW)) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_dot_mask(i_dot_mask),
        .i_digit_en(i_digit_en), .i_load(i_load), .i_lz_blank(i_lz_blank),
        .i_brightness(i_brightness), .o_anodes(o_anodes), .o_segments(o_segments),
        .o_frame_done(o_frame_done));

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                 7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    int          checks = 0, errors = 0;
    int          t = 0;
    logic [15:0] m_act = '0, m_pend = '0;
    logic [3:0]  m_dots = '0, m_en = '1, m_pdots = '0, m_pen = '0;
    bit          m_pflag = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic step();
        logic [3:0] exp_an;
        logic [7:0] exp_seg;
        logic       exp_fd, on, blank, dot;
        int         c, d;
        string      tag;
        if (rst) begin
            exp_an = 4'hF; exp_seg = 8'h00; exp_fd = 1'b0;
            t = 0; m_act = '0; m_dots = '0; m_en = '1; m_pflag = 0;
            tag = "reset";
        end else begin
            c = t % DC;
            d = (t / DC) % ND;
            dot = m_dots[d];
            blank = i_lz_blank && (d > 0) && ((m_act >> (4 * d)) == 16'h0);
            on = (c >= BC) && ((c % (1 << BW)) <= int'(i_brightness)) && m_en[d] && !(blank && !dot);
            exp_an  = on ? ~(4'b0001 << d) : 4'hF;
            exp_seg = on ? {(blank ? 7'b0 : seg_tab[(m_act >> (4 * d)) & 16'hF]), dot} : 8'h00;
            exp_fd  = ((t % FRAME) == FRAME - 1);
            if (((t % FRAME) == FRAME - 1) && m_pflag) begin
                m_act = m_pend; m_dots = m_pdots; m_en = m_pen; m_pflag = 0;
            end
            if (i_load) begin
                m_pend = i_data; m_pdots = i_dot_mask; m_pen = i_digit_en; m_pflag = 1;
            end
            t++;
            tag = "scan";
        end
        @(posedge clk);
        #1;
        chk({tag, "_anodes"}, {4'h0, o_anodes}, {4'h0, exp_an});
        chk({tag, "_segments"}, o_segments, exp_seg);
        chk({tag, "_frame_done"}, {7'h0, o_frame_done}, {7'h0, exp_fd});
        chk("one_anode_max", {7'h0, $countones(~o_anodes) <= 1}, 8'h01);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input logic [15:0] data, input logic [3:0] dots, input logic [3:0] en);
        i_data = data; i_dot_mask = dots; i_digit_en = en; i_load = 1'b1;
        step();
        i_load = 1'b0;
    endtask

    task automatic run_to_boundary();
        while ((t % FRAME) != FRAME - 1) step();
    endtask

    initial begin
        // reset and basic 0x1234 display
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        i_brightness = 2'd3;
        load(16'h1234, 4'h0, 4'hF);
        run(200);
        // brightness levels
        i_brightness = 2'd0;
        run(64);
        i_brightness = 2'd1;
        run(64);
        i_brightness = 2'd2;
        run(64);
        i_brightness = 2'd3;
        // leading-zero suppression with a dot on a blanked digit
        i_lz_blank = 1'b1;
        load(16'h0070, 4'b1000, 4'hF);
        run(140);
        i_lz_blank = 1'b0;
        run(64);
        // mid-frame load, then a load on the boundary cycle itself
        run(20);
        load(16'hAAAA, 4'h0, 4'hF);
        run_to_boundary();
        load(16'h5555, 4'h0, 4'hF);
        run(140);
        // digit enables
        load(16'h9876, 4'hF, 4'b0101);
        run(150);
        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [15:0] d;
            for (int k = 0; k < 4; k++)
                d[4*k +: 4] = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(0, 15));
            i_brightness = BW'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) i_lz_blank = ~i_lz_blank;
            i_data = d;
            i_dot_mask = 4'($urandom);
            i_digit_en = 4'($urandom);
            i_load = ($urandom_range(0, 15) == 0);
            step();
        end
        i_load = 1'b0;
        // reset mid-slot of digit 2 with a load pending
        i_brightness = 2'd3;
        i_lz_blank = 1'b0;
        run_to_boundary();
        load(16'h4321, 4'h0, 4'hF);
        run(64);
        load(16'hFEDC, 4'hF, 4'hF);
        while ((((t / DC) % ND) != 2) || ((t % DC) != 7)) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(140);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
